// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALT
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer; flush wins over push and pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fifo_entry_t                push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output fifo_entry_t                head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC, single-outstanding imem requests, redirect/squash, HLT stop
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_squashed counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] PC_STEP    = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_squashed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t      state, state_next;
    logic [15:0] fetch_pc, req_pc;
    logic        squash, hlt_seen;
    logic [CW-1:0] count;
    logic        head_valid;
    fifo_entry_t head, push_entry;
    logic        redirect, resp, resp_hlt, push, pop, issue;
    int          free;

    assign redirect   = redirect_valid && (state != HALT);
    assign resp       = (state == WAIT) && imem_ready;
    assign resp_hlt   = resp && !squash && (imem_rdata[15:12] == OPC_HLT);
    assign push       = resp && !squash && !redirect;
    assign if_valid   = head_valid && (state != HALT);
    assign pop        = if_valid && id_ready && !redirect;
    assign push_entry = '{instr: imem_rdata, pc: req_pc};

    // The outstanding request already owns a slot; a same-cycle pop gives one back.
    assign free = FIFO_DEPTH - int'(count) - ((state == WAIT) ? 1 : 0) + (pop ? 1 : 0);

    assign issue = rst_n && ((state == IDLE) || resp) && (free > 0)
                   && !hlt_seen && !redirect_valid && !resp_hlt;

    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc : 16'h0000;

    always_comb begin
        state_next = state;
        if (state != HALT) begin
            if (redirect)
                state_next = ((state == WAIT) && !imem_ready) ? WAIT : IDLE;
            else if (pop && (head.instr[15:12] == OPC_HLT))
                state_next = HALT;
            else if (issue)
                state_next = WAIT;
            else if (resp)
                state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            squash   <= 1'b0;
            hlt_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                squash   <= (state == WAIT) && !imem_ready;
                hlt_seen <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                    req_pc   <= fetch_pc;
                end
                if (resp && squash) squash <= 1'b0;
                if (resp_hlt) hlt_seen <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head_valid(head_valid),
        .head      (head)
    );

    assign if_instr    = if_valid ? head.instr : 16'h0000;
    assign if_pc       = if_valid ? head.pc : 16'h0000;
    assign if_pc_plus2 = if_valid ? head.pc + PC_STEP : 16'h0000;
    assign halted      = (state == HALT);

`ifdef FETCH_PERF_EN
    logic [16:0] fetched_sum, squashed_sum;

    assign fetched_sum  = {1'b0, perf_fetched} + 17'(push);
    assign squashed_sum = {1'b0, perf_squashed} + 17'(resp && (squash || redirect))
                          + (redirect ? 17'(count) : 17'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched  <= 16'h0000;
            perf_squashed <= 16'h0000;
        end else begin
            perf_fetched  <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
            perf_squashed <= squashed_sum[16] ? 16'hFFFF : squashed_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_squashed;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus2   (if_pc_plus2),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    int          lat = 1;
    bit          hlt_mode = 1'b0;
    int          pend = 0;
    logic [15:0] paddr = 16'h0000;
    logic [15:0] req_log[$];
    logic [47:0] expq[$];
    int          errors = 0;
    int          checks = 0;
    int          npops = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (hlt_mode && a == 16'h0000) return 16'h1234;
        if (hlt_mode && a == 16'h0002) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    function automatic logic [31:0] rq(input int i);
        if (i < req_log.size()) return {16'h0000, req_log[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [15:0] instr);
        logic [15:0] pc2;
        pc2 = pc + 16'd2;
        expq.push_back({instr, pc, pc2});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input int l, input logic idr, input bit hm);
        rst_n = 1'b0;
        tick(4);
        lat      = l;
        id_ready = idr;
        hlt_mode = hm;
        req_log.delete();
        npops = 0;
        rst_n = 1'b1;
    endtask

    task automatic finish_scn(input string name, input int exp_pops);
        rst_n = 1'b0;
        chk({name, "_pops"}, npops, exp_pops);
        chk({name, "_left"}, expq.size(), 0);
        expq.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        #4;
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_valid"}, if_valid, 0);
        chk({tag, "_instr"}, if_instr, 0);
        chk({tag, "_pc"}, if_pc, 0);
        chk({tag, "_pc2"}, if_pc_plus2, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    // Memory: response imem_ready 'lat' cycles after the request cycle.
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            imem_ready = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = memf(paddr);
                end
            end
            #3;
            if (imem_req) begin
                paddr = imem_addr;
                pend  = lat;
                req_log.push_back(imem_addr);
            end
        end
    end

    // Monitor: compare every accepted head against the expected queue.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && if_valid && id_ready && !redirect_valid) begin
                npops++;
                chk("pop_expected", (expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("pop_instr", if_instr, e[47:32]);
                    chk("pop_pc", if_pc, e[31:16]);
                    chk("pop_pc_plus2", if_pc_plus2, e[15:0]);
                end
            end
        end
    end

    initial begin
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        tick(1);
        chk_reset_outputs("rst0");

        // Streaming with 1-cycle memory
        for (int i = 0; i < 6; i++) push_exp(16'(2 * i), 16'h1000 + 16'(2 * i));
        start(1, 1'b1, 1'b0);
        tick(2);
        #4;
        chk("s1_valid", if_valid, 1);
        chk("s1_pc", if_pc, 16'h0000);
        chk("s1_pc2", if_pc_plus2, 16'h0002);
        tick(6);
        finish_scn("s1", 6);
        chk("s1_req0", rq(0), 16'h0000);
        chk("s1_req1", rq(1), 16'h0002);
        chk("s1_req2", rq(2), 16'h0004);
        chk_reset_outputs("rst1");

        // Back-pressure: FIFO fills to depth, then drains in order
        for (int i = 0; i < 4; i++) push_exp(16'(2 * i), 16'h1000 + 16'(2 * i));
        start(1, 1'b0, 1'b0);
        tick(3);
        for (int k = 3; k <= 5; k++) begin
            #4;
            chk("s2_hold_req", imem_req, 0);
            chk("s2_hold_valid", if_valid, 1);
            chk("s2_hold_pc", if_pc, 16'h0000);
            tick(1);
        end
        chk("s2_nreq", req_log.size(), 2);
        id_ready = 1'b1;
        tick(4);
        finish_scn("s2", 4);

        // Redirect while waiting on a 3-cycle response; buffered entry flushed
        push_exp(16'h0000, 16'h1000);
        push_exp(16'h0002, 16'h1002);
        push_exp(16'h0100, 16'h1100);
        start(3, 1'b1, 1'b0);
        tick(10);
        id_ready = 1'b0;
        tick(1);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #4;
        chk("s3_redir_req", imem_req, 0);
        tick(1);
        redirect_valid = 1'b0;
        #4;
        chk("s3_flushed", if_valid, 0);
        chk("s3_req", imem_req, 1);
        chk("s3_addr", imem_addr, 16'h0100);
        tick(4);
`ifdef FETCH_PERF_EN
        #4;
        chk("s3_perf_fetched", perf_fetched, 4);
        chk("s3_perf_squashed", perf_squashed, 2);
`endif
        tick(1);
        finish_scn("s3", 3);
        chk("s3_nreq", req_log.size(), 6);
        chk("s3_req_target", rq(4), 16'h0100);

        // Redirect coincident with the response
        push_exp(16'h0200, 16'h1200);
        start(3, 1'b1, 1'b0);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        #4;
        chk("s4_redir_req", imem_req, 0);
        tick(1);
        redirect_valid = 1'b0;
        #4;
        chk("s4_req", imem_req, 1);
        chk("s4_addr", imem_addr, 16'h0200);
        chk("s4_empty", if_valid, 0);
        tick(4);
`ifdef FETCH_PERF_EN
        #4;
        chk("s4_perf_fetched", perf_fetched, 1);
        chk("s4_perf_squashed", perf_squashed, 1);
`endif
        tick(1);
        finish_scn("s4", 1);

        // PC wrap at 0xFFFE
        push_exp(16'hFFFE, 16'h1FFE);
        push_exp(16'h0000, 16'h1000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        start(1, 1'b1, 1'b0);
        tick(1);
        redirect_valid = 1'b0;
        #4;
        chk("s5_addr_fffe", imem_addr, 16'hFFFE);
        tick(1);
        #4;
        chk("s5_addr_wrap", imem_addr, 16'h0000);
        tick(1);
        #4;
        chk("s5_pc", if_pc, 16'hFFFE);
        chk("s5_pc2_wrap", if_pc_plus2, 16'h0000);
        tick(2);
        finish_scn("s5", 2);

        // HLT: fetch stops, halted after pop, redirect ignored, reset recovers
        push_exp(16'h0000, 16'h1234);
        push_exp(16'h0002, 16'hF000);
        start(1, 1'b1, 1'b1);
        tick(2);
        #4;
        chk("s6_no_req_after_hlt", imem_req, 0);
        chk("s6_not_yet_halted", halted, 0);
        tick(2);
        #4;
        chk("s6_halted", halted, 1);
        chk("s6_valid_off", if_valid, 0);
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        #4;
        chk("s6_still_halted", halted, 1);
        chk("s6_req_off", imem_req, 0);
        chk("s6_nreq", req_log.size(), 2);
        tick(1);
        finish_scn("s6", 2);
        chk_reset_outputs("rst6");

        push_exp(16'h0000, 16'h1000);
        push_exp(16'h0002, 16'h1002);
        start(1, 1'b1, 1'b0);
        tick(4);
        finish_scn("s7", 2);
        chk("s7_restart_pc", rq(0), 16'h0000);

        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
